// File: rtl/lif_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } lif_state_t;

  localparam logic [7:0] DEFAULT_THRESHOLD   = 8'd200;
  localparam int         DEFAULT_NUM_NEURONS = 4;
  localparam int         ADDR_THRESH         = DEFAULT_NUM_NEURONS;

  // The threshold register sits one address above the last current register.
  function automatic int thresh_addr(input int num_neurons);
    return num_neurons;
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leak/integrate/fire rule shared by every virtual neuron.
module lif_update #(
  parameter int LEAK_SHIFT = 1
) (
  input  logic [7:0] state,
  input  logic [7:0] current,
  input  logic [7:0] threshold,
  output logic [7:0] next_state,
  output logic       spike
);

  logic [9:0] sum_wide;
  logic [7:0] sum_sat;

  // Ten bits hold the worst case of 255 + 255 before clamping to 8 bits.
  always_comb begin
    sum_wide   = {2'b00, state} - ({2'b00, state} >> LEAK_SHIFT) + {2'b00, current};
    sum_sat    = (sum_wide > 10'd255) ? 8'hFF : sum_wide[7:0];
    spike      = (sum_sat >= threshold);
    next_state = spike ? (sum_sat - threshold) : sum_sat;
  end

endmodule

// File: rtl/lif_scheduler.sv
// Sweeps one shared lif_update datapath over all virtual neurons once per
// timestep tick; also holds the config registers, spike vector and monitor.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int          NUM_NEURONS = 4,
  parameter logic [23:0] TICK_CYCLES = 24'd10_000_000,
  parameter logic [7:0]  THRESHOLD   = DEFAULT_THRESHOLD,
  parameter int          LEAK_SHIFT  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_NEURONS):0]   cfg_addr,
  input  logic [7:0]                     cfg_data,
  input  logic [$clog2(NUM_NEURONS)-1:0] mon_sel,
  output logic [7:0]                     mon_state,
  output logic [NUM_NEURONS-1:0]         spikes,
  output logic                           sweep_done,
  output logic                           busy,
  output logic                           overrun
);

  localparam int               IW        = $clog2(NUM_NEURONS);
  localparam logic [IW-1:0]    LAST_IDX  = IW'(NUM_NEURONS - 1);
  localparam logic [IW:0]      THR_ADDR  = (IW + 1)'(thresh_addr(NUM_NEURONS));
  localparam logic [23:0]      TICK_LAST = TICK_CYCLES - 24'd1;

  lif_state_t             fsm_q, fsm_d;
  logic [23:0]            prescale;
  logic                   tick;
  logic [IW-1:0]          idx;
  logic [7:0]             membrane [NUM_NEURONS];
  logic [7:0]             current  [NUM_NEURONS];
  logic [7:0]             threshold;
  logic [7:0]             op_state, op_current, upd_state;
  logic                   upd_spike;
  logic [NUM_NEURONS-1:0] shadow, shadow_next;

  assign tick       = ena && (prescale == TICK_LAST);
  assign busy       = (fsm_q != IDLE);
  assign sweep_done = (fsm_q == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale <= '0;
    end else if (ena) begin
      prescale <= (prescale == TICK_LAST) ? 24'd0 : prescale + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (tick) fsm_d = READ;
      READ:    fsm_d = WRITE;
      WRITE:   fsm_d = (idx == LAST_IDX) ? DONE : READ;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    shadow_next      = shadow;
    shadow_next[idx] = upd_spike;
  end

  lif_update #(.LEAK_SHIFT(LEAK_SHIFT)) u_update (
    .state      (op_state),
    .current    (op_current),
    .threshold  (threshold),
    .next_state (upd_state),
    .spike      (upd_spike)
  );

  // Spikes are published from the last WRITE so they are already visible
  // during the DONE cycle alongside the sweep_done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      op_state   <= '0;
      op_current <= '0;
      shadow     <= '0;
      spikes     <= '0;
      overrun    <= 1'b0;
      mon_state  <= '0;
      threshold  <= THRESHOLD;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        membrane[i] <= '0;
        current[i]  <= '0;
      end
    end else begin
      mon_state <= membrane[mon_sel];
      if (tick && (fsm_q != IDLE)) overrun <= 1'b1;
      if (cfg_we) begin
        if (!cfg_addr[IW]) current[cfg_addr[IW-1:0]] <= cfg_data;
        else if (cfg_addr == THR_ADDR) threshold <= (cfg_data == 8'd0) ? 8'd1 : cfg_data;
      end
      case (fsm_q)
        IDLE: if (tick) idx <= '0;
        READ: begin
          op_state   <= membrane[idx];
          op_current <= current[idx];
        end
        WRITE: begin
          membrane[idx] <= upd_state;
          shadow        <= shadow_next;
          if (idx == LAST_IDX) spikes <= shadow_next;
          else                 idx    <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_scheduler.sv
// Randomized scoreboard bench for lif_scheduler against a per-timestep
// reference model, plus directed integrate/fire, saturation and config cases.
module tb_lif_scheduler;

  localparam int N     = 4;
  localparam int TICKS = 16;

  logic       clk = 1'b0;
  logic       rst_n, ena, cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [1:0] mon_sel;

  logic [7:0]   mon_state, ovr_mon_state;
  logic [N-1:0] spikes, ovr_spikes;
  logic         sweep_done, busy, overrun;
  logic         ovr_sweep_done, ovr_busy, ovr_overrun;

  always #5 clk = ~clk;

  lif_scheduler #(.NUM_NEURONS(N), .TICK_CYCLES(24'd16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .mon_sel(mon_sel), .mon_state(mon_state), .spikes(spikes),
    .sweep_done(sweep_done), .busy(busy), .overrun(overrun)
  );

  // Deliberately too-short timestep so ticks land inside sweeps.
  lif_scheduler #(.NUM_NEURONS(N), .TICK_CYCLES(24'd8)) dut_ovr (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .mon_sel(mon_sel), .mon_state(ovr_mon_state), .spikes(ovr_spikes),
    .sweep_done(ovr_sweep_done), .busy(ovr_busy), .overrun(ovr_overrun)
  );

  typedef struct {
    logic       busy;
    logic       done;
    logic       ovr;
    logic [7:0] mon;
  } status_t;

  typedef struct {
    logic [N-1:0] spk;
    int           cyc;
  } sweep_t;

  status_t status_q[$];
  sweep_t  sweep_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ovr_dones = 0;
  bit model_valid = 0;

  int           m_mem [N];
  int           m_cur [N];
  int           m_snap[N];
  int           m_thr;
  int           en_cnt;
  bit           m_active;
  int           m_t;
  logic [N-1:0] m_shadow, m_spikes;
  logic         m_ovr;
  logic [7:0]   m_mon;
  int           sweeps_done = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void ref_update(input int s, input int c, input int thr, output int nxt, output bit spk);
    int sum;
    sum = s - s / 2 + c;
    if (sum > 255) sum = 255;
    spk = (sum >= thr);
    nxt = spk ? sum - thr : sum;
  endfunction

  // Drive one cycle and advance the reference model by one cycle of timestep rules.
  task automatic applyStimulus(input bit r, input bit e, input bit we, input logic [2:0] a,
                               input logic [7:0] d, input logic [1:0] sel);
    bit   busy_v, done_v, tick, spk;
    int   p, nxt;
    logic [7:0] next_mon;
    @(negedge clk);
    rst_n = r; ena = e; cfg_we = we; cfg_addr = a; cfg_data = d; mon_sel = sel;
    cyc++;
    busy_v = m_active && (cyc >= m_t + 1) && (cyc <= m_t + 2 * N + 1);
    done_v = m_active && (cyc == m_t + 2 * N + 1);
    if (model_valid) begin
      status_q.push_back('{busy_v, done_v, m_ovr, m_mon});
      if (done_v) begin
        sweep_q.push_back('{m_spikes, cyc});
        sweeps_done++;
      end
    end
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        m_mem[k] = 0;
        m_cur[k] = 0;
      end
      m_thr = 200; en_cnt = 0; m_active = 0; m_spikes = '0; m_shadow = '0;
      m_ovr = 1'b0; m_mon = 8'd0; model_valid = 1;
    end else begin
      next_mon = 8'(m_mem[sel]);
      if (e) en_cnt++;
      tick = e && (en_cnt % TICKS == 0);
      if (m_active) begin
        p = cyc - m_t;
        for (int k = 0; k < N; k++) begin
          if (p == 1 + 2 * k) m_snap[k] = m_cur[k];
          if (p == 2 + 2 * k) begin
            ref_update(m_mem[k], m_snap[k], m_thr, nxt, spk);
            m_mem[k]    = nxt;
            m_shadow[k] = spk;
            if (k == N - 1) m_spikes = m_shadow;
          end
        end
      end
      if (tick) begin
        if (busy_v) m_ovr = 1'b1;
        else begin
          m_active = 1;
          m_t      = cyc;
        end
      end
      if (we) begin
        if (a < 3'(N)) m_cur[a[1:0]] = d;
        else if (a == 3'(N)) m_thr = (d == 8'd0) ? 1 : d;
      end
      m_mon = next_mon;
    end
  endtask

  // Run until the model has seen n more sweeps; optionally collide a write
  // to current[2] with the READ of neuron 2 in the first sweep.
  task automatic runSweeps(input int n, input logic [1:0] sel, input bit force2, input logic [7:0] d2);
    int  target, budget;
    bit  pending, we;
    target  = sweeps_done + n;
    budget  = 60 * n;
    pending = force2;
    while (sweeps_done < target && budget > 0) begin
      we = pending && m_active && (cyc + 1 - m_t == 5);
      if (we) pending = 0;
      applyStimulus(1, 1, we, 3'd2, d2, sel);
      budget--;
    end
  endtask

  task automatic idleCycles(input int n, input logic [1:0] sel);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 3'd0, 8'd0, sel);
  endtask

  initial begin : monitor
    status_t s;
    sweep_t  w;
    forever begin
      @(negedge clk);
      #2;
      while (status_q.size() > 0) begin
        s = status_q.pop_front();
        checkOutput("busy", 32'(busy), 32'(s.busy));
        checkOutput("sweep_done", 32'(sweep_done), 32'(s.done));
        checkOutput("overrun", 32'(overrun), 32'(s.ovr));
        checkOutput("mon_state", 32'(mon_state), 32'(s.mon));
      end
      if (ovr_sweep_done === 1'b1) ovr_dones++;
      if (sweep_done === 1'b1) begin
        if (sweep_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done: got sweep_done=1 expected no sweep (cycle %0d)", cyc);
        end else begin
          w = sweep_q.pop_front();
          checkOutput("spikes", 32'(spikes), 32'(w.spk));
          checkOutput("done_cycle", 32'(cyc), 32'(w.cyc));
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 0; ena = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0; mon_sel = '0;
    applyStimulus(0, 0, 0, 3'd0, 8'd0, 2'd0);
    applyStimulus(0, 0, 0, 3'd0, 8'd0, 2'd0);
    #2;
    checkOutput("reset_spikes", 32'(spikes), 32'd0);
    checkOutput("reset_ovr_overrun", 32'(ovr_overrun), 32'd0);

    // Integrate and fire: 150 -> 225 fires and leaves 25.
    applyStimulus(1, 1, 1, 3'd0, 8'd150, 2'd0);
    runSweeps(1, 2'd0, 0, 8'd0);
    #2;
    checkOutput("fire_sweep1_spikes", 32'(spikes), 32'h0);
    runSweeps(1, 2'd0, 0, 8'd0);
    #2;
    checkOutput("fire_sweep2_spikes", 32'(spikes), 32'h1);
    checkOutput("ovr_sticky", 32'(ovr_overrun), 32'd1);
    checkOutput("ovr_sweeps_complete", 32'(ovr_dones), 32'd2);
    idleCycles(3, 2'd0);
    #2;
    checkOutput("fire_state0", 32'(mon_state), 32'd25);

    // Threshold 0 is stored as 1, so a current of 1 fires every sweep.
    applyStimulus(0, 0, 0, 3'd0, 8'd0, 2'd0);
    applyStimulus(1, 1, 1, 3'd4, 8'd0, 2'd3);
    #2;
    checkOutput("ovr_cleared", 32'(ovr_overrun), 32'd0);
    for (int k = 0; k < N; k++) applyStimulus(1, 1, 1, 3'(k), 8'd1, 2'd3);
    runSweeps(2, 2'd3, 0, 8'd0);
    #2;
    checkOutput("thr0_spikes", 32'(spikes), 32'hF);

    // Saturation: 200 - 100 + 255 clamps to 255, fires at 255, leaves 0.
    applyStimulus(0, 0, 0, 3'd0, 8'd0, 2'd1);
    applyStimulus(1, 1, 1, 3'd4, 8'd255, 2'd1);
    applyStimulus(1, 1, 1, 3'd1, 8'd200, 2'd1);
    runSweeps(1, 2'd1, 0, 8'd0);
    applyStimulus(1, 1, 1, 3'd1, 8'd255, 2'd1);
    runSweeps(1, 2'd1, 0, 8'd0);
    #2;
    checkOutput("sat_spikes", 32'(spikes), 32'h2);
    idleCycles(3, 2'd1);
    #2;
    checkOutput("sat_state1", 32'(mon_state), 32'd0);

    // Write collides with READ of neuron 2: old current this sweep, new next.
    applyStimulus(0, 0, 0, 3'd0, 8'd0, 2'd2);
    runSweeps(1, 2'd2, 1, 8'd150);
    idleCycles(3, 2'd2);
    #2;
    checkOutput("collide_old", 32'(mon_state), 32'd0);
    applyStimulus(1, 0, 1, 3'd7, 8'd99, 2'd2);
    applyStimulus(1, 0, 1, 3'd6, 8'd99, 2'd2);
    runSweeps(1, 2'd2, 0, 8'd0);
    idleCycles(3, 2'd2);
    #2;
    checkOutput("collide_new", 32'(mon_state), 32'd150);
    idleCycles(2, 2'd3);
    #2;
    checkOutput("addr7_ignored", 32'(mon_state), 32'd0);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      applyStimulus((i == 700) ? 1'b0 : 1'b1, ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)), d,
                    2'($urandom_range(0, 3)));
    end
    idleCycles(2, 2'd0);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
